// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data, an empty-state
// write-to-read bypass, and full/empty decoded from the occupancy count.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_do_wr;
  logic w_do_rd;

  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  // On an empty FIFO a simultaneous read/write hands din straight to dout.
  assign w_bypass = wr & rd & w_empty;
  assign w_do_rd  = rd & ~w_empty;
  // A full FIFO still accepts a write when the same edge frees a slot.
  assign w_do_wr  = wr & (~w_full | rd) & ~w_bypass;

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers, occupancy count and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + PTR_ONE;
        r_dout <= r_mem[r_rptr];
      end else if (w_bypass) begin
        r_dout <= din;
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  assign dout  = r_dout;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo at WIDTH=24, DEPTH=16.
module tb_fifo;

  localparam int WIDTH = 24;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  int n_checks;
  int n_fail;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_q [16];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = '0;
    rst = 1'b0;
    #12;
    check_val("rst_empty", {31'd0, empty}, 32'd1);
    check_val("rst_full",  {31'd0, full},  32'd0);
    check_val("rst_dout",  {8'd0, dout},   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill, then overfill.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 24'h123450 + 24'(i));
      check_val("fill_full", {31'd0, full}, (i == 15) ? 32'd1 : 32'd0);
      check_val("fill_empty", {31'd0, empty}, 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 24'hFFFFF0 + 24'(i));
      check_val("ovf_full", {31'd0, full}, 32'd1);
      check_val("ovf_dout", {8'd0, dout}, 32'd0);
    end

    // Drain, then underflow.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 24'h000000);
      check_val("drain_dout", {8'd0, dout}, 32'h123450 + i);
      check_val("drain_empty", {31'd0, empty}, (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 24'h000000);
      check_val("udf_dout", {8'd0, dout}, 32'h12345F);
      check_val("udf_empty", {31'd0, empty}, 32'd1);
    end

    // Empty bypass.
    cyc(1'b1, 1'b1, 24'h555555);
    check_val("byp_dout",  {8'd0, dout},   32'h555555);
    check_val("byp_empty", {31'd0, empty}, 32'd1);
    check_val("byp_full",  {31'd0, full},  32'd0);
    cyc(1'b0, 1'b0, 24'h000000);
    check_val("byp_hold", {8'd0, dout}, 32'h555555);

    // Mid-level simultaneous access.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 24'hABCDEF + 24'(i));
    end
    cyc(1'b1, 1'b1, 24'h808080);
    check_val("mid_dout",  {8'd0, dout},   32'hABCDEF);
    check_val("mid_empty", {31'd0, empty}, 32'd0);

    // Fill to full, then simultaneous access while full.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 1'b0, 24'(i));
      check_val("top_full", {31'd0, full}, (i == 10) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 1'b1, 24'hFFFFFF);
    check_val("fullrw_dout", {8'd0, dout}, 32'hABCDF0);
    check_val("fullrw_full", {31'd0, full}, 32'd1);

    exp_q[0] = 24'hABCDF1;
    exp_q[1] = 24'hABCDF2;
    exp_q[2] = 24'hABCDF3;
    exp_q[3] = 24'h808080;
    for (int i = 0; i < 11; i++) exp_q[4 + i] = 24'(i);
    exp_q[15] = 24'hFFFFFF;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 24'h000000);
      check_val("wrap_dout", {8'd0, dout}, {8'd0, exp_q[i]});
      check_val("wrap_empty", {31'd0, empty}, (i == 15) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b0, 24'h000000);
    check_val("wrap_hold", {8'd0, dout}, 32'hFFFFFF);

    // Async reset between edges with the FIFO partly filled.
    cyc(1'b1, 1'b0, 24'h0A0A0A);
    cyc(1'b1, 1'b0, 24'h0B0B0B);
    cyc(1'b0, 1'b1, 24'h000000);
    check_val("pre_rst_dout", {8'd0, dout}, 32'h0A0A0A);
    wr = 1'b0;
    rd = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_empty", {31'd0, empty}, 32'd1);
    check_val("arst_full",  {31'd0, full},  32'd0);
    check_val("arst_dout",  {8'd0, dout},   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First write after reset is read back first.
    cyc(1'b1, 1'b0, 24'h000111);
    cyc(1'b1, 1'b0, 24'h000222);
    cyc(1'b0, 1'b1, 24'h000000);
    check_val("post_rst_first", {8'd0, dout}, 32'h000111);
    cyc(1'b0, 1'b1, 24'h000000);
    check_val("post_rst_second", {8'd0, dout}, 32'h000222);
    check_val("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
